// File: rtl/param_code_lock_if.sv
// rtl/param_code_lock_if.sv - keypad inputs and lock status outputs of param_code_lock
interface param_code_lock_if #(
  parameter int NDIGITS = 4,
  parameter int DIGIT_W = 4
);
  logic                       ent_p;
  logic                       clr_p;
  logic                       chg_p;
  logic [DIGIT_W-1:0]         sw;
  logic [2:0]                 state_o;
  logic                       unlocked;
  logic                       lockout;
  logic [3:0]                 digit_idx;
  logic [NDIGITS*DIGIT_W-1:0] entry;
  logic [3:0]                 fail_cnt;
  logic                       ok_p;
  logic                       err_p;

  modport master (
    output ent_p, clr_p, chg_p, sw,
    input  state_o, unlocked, lockout, digit_idx, entry, fail_cnt, ok_p, err_p
  );

  modport slave (
    input  ent_p, clr_p, chg_p, sw,
    output state_o, unlocked, lockout, digit_idx, entry, fail_cnt, ok_p, err_p
  );
endinterface

// File: rtl/param_code_lock.sv
// rtl/param_code_lock.sv - keypad code lock FSM with timed lockout and code change
// Define CODE_CHANGE_CONFIRM_EN to require the new code to be entered twice.
module param_code_lock #(
  parameter int NDIGITS     = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 100000000,
  parameter logic [NDIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
  input logic              clk,
  input logic              rst,
  param_code_lock_if.slave bus
);

  localparam int CODE_W = NDIGITS * DIGIT_W;
  localparam int CNT_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [3:0]       LAST_IDX    = 4'(NDIGITS - 1);
  localparam logic [3:0]       MAX_TRIES_4 = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_ENTER_L  = 3'd1,
    S_UNLOCKED = 3'd2,
    S_ENTER_U  = 3'd3,
    S_NEW_CODE = 3'd4,
`ifdef CODE_CHANGE_CONFIRM_EN
    S_CONFIRM  = 3'd5,
`endif
    S_LOCKOUT  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] entry_q, entry_d;
  logic [3:0]        digit_idx_q, digit_idx_d;
  logic [3:0]        fail_cnt_q, fail_cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic              unlocked_q, unlocked_d;
  logic              lockout_q, lockout_d;
`ifdef CODE_CHANGE_CONFIRM_EN
  logic [CODE_W-1:0] pending_q, pending_d;
`endif

  logic [CODE_W-1:0] assembled;
  logic [3:0]        fail_inc;
  logic              is_last;

  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] cur,
                                                  input logic [3:0] idx,
                                                  input logic [DIGIT_W-1:0] d);
    logic [CODE_W-1:0] r;
    r = cur;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == 4'(i)) r[(NDIGITS-1-i)*DIGIT_W +: DIGIT_W] = d;
    end
    return r;
  endfunction

  // The last digit is compared straight from sw so the verdict needs no extra cycle.
  assign assembled = {entry_q[CODE_W-1:DIGIT_W], bus.sw};
  assign is_last   = (digit_idx_q == LAST_IDX);
  assign fail_inc  = (fail_cnt_q == 4'hf) ? 4'hf : fail_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    digit_idx_d = digit_idx_q;
    fail_cnt_d  = fail_cnt_q;
    code_d      = code_q;
    lock_cnt_d  = lock_cnt_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
`ifdef CODE_CHANGE_CONFIRM_EN
    pending_d   = pending_q;
`endif

    case (state_q)
      S_LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          state_d    = S_LOCKED;
          fail_cnt_d = 4'd0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
      S_LOCKED: begin
        if (bus.ent_p) begin
          entry_d     = put_digit(entry_q, digit_idx_q, bus.sw);
          digit_idx_d = digit_idx_q + 4'd1;
          state_d     = S_ENTER_L;
        end
      end
      S_UNLOCKED: begin
        if (bus.ent_p) begin
          entry_d     = put_digit(entry_q, digit_idx_q, bus.sw);
          digit_idx_d = digit_idx_q + 4'd1;
          state_d     = S_ENTER_U;
        end else if (bus.chg_p) begin
          entry_d     = '0;
          digit_idx_d = 4'd0;
          state_d     = S_NEW_CODE;
        end
      end
      default: begin
        if (bus.clr_p) begin
          entry_d     = '0;
          digit_idx_d = 4'd0;
        end else if (bus.ent_p && !is_last) begin
          entry_d     = put_digit(entry_q, digit_idx_q, bus.sw);
          digit_idx_d = digit_idx_q + 4'd1;
        end else if (bus.ent_p) begin
          entry_d     = '0;
          digit_idx_d = 4'd0;
          case (state_q)
            S_ENTER_L: begin
              if (assembled == code_q) begin
                state_d    = S_UNLOCKED;
                fail_cnt_d = 4'd0;
                ok_d       = 1'b1;
              end else begin
                err_d      = 1'b1;
                fail_cnt_d = fail_inc;
                if (fail_inc == MAX_TRIES_4) begin
                  state_d    = S_LOCKOUT;
                  lock_cnt_d = CNT_LOAD;
                end else begin
                  state_d = S_LOCKED;
                end
              end
            end
            S_ENTER_U: begin
              if (assembled == code_q) begin
                state_d = S_LOCKED;
                ok_d    = 1'b1;
              end else begin
                state_d = S_UNLOCKED;
                err_d   = 1'b1;
              end
            end
`ifdef CODE_CHANGE_CONFIRM_EN
            S_NEW_CODE: begin
              pending_d = assembled;
              state_d   = S_CONFIRM;
            end
            S_CONFIRM: begin
              state_d = S_UNLOCKED;
              if (assembled == pending_q) begin
                code_d = pending_q;
                ok_d   = 1'b1;
              end else begin
                err_d  = 1'b1;
              end
            end
`else
            S_NEW_CODE: begin
              code_d  = assembled;
              state_d = S_UNLOCKED;
              ok_d    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
    endcase

    // Relock entry still counts as unlocked: the door is open until the code is accepted.
    unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_ENTER_U) ||
`ifdef CODE_CHANGE_CONFIRM_EN
                 (state_d == S_CONFIRM) ||
`endif
                 (state_d == S_NEW_CODE);
    lockout_d  = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOCKED;
      entry_q     <= '0;
      digit_idx_q <= 4'd0;
      fail_cnt_q  <= 4'd0;
      code_q      <= RESET_CODE;
      lock_cnt_q  <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
`ifdef CODE_CHANGE_CONFIRM_EN
      pending_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      digit_idx_q <= digit_idx_d;
      fail_cnt_q  <= fail_cnt_d;
      code_q      <= code_d;
      lock_cnt_q  <= lock_cnt_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      unlocked_q  <= unlocked_d;
      lockout_q   <= lockout_d;
`ifdef CODE_CHANGE_CONFIRM_EN
      pending_q   <= pending_d;
`endif
    end
  end

  assign bus.state_o   = state_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.lockout   = lockout_q;
  assign bus.digit_idx = digit_idx_q;
  assign bus.entry     = entry_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.ok_p      = ok_q;
  assign bus.err_p     = err_q;

endmodule
